seq7seg_monitor: RTL
====================

Name: seq7seg_monitor

Overview:
- Receive-side checker for the two-digit 7-segment sequence display.
- Watches the seg1/seg0 patterns driven by the sequence display block, deglitches them and decodes them back to a binary value.
- Locates the value in the fixed sequence table, infers the counting direction, and flags every out-of-sequence or illegal display.
- Used in self-checking benches and on-board, probing the display bus.

Parameters:
- n, 4, width of one decoded digit (BCD nibble).
- STABLE_CYC, 4, consecutive clk cycles a pattern pair must be held before it is accepted (range 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- seg1  in  7  tens-digit segments, active-low, bit0=a … bit6=g
- seg0  in  7  units-digit segments, same encoding
- value  out  7  last accepted decoded value (tens*10+units, 0..99)
- value_valid  out  1  value holds a legally decoded pattern
- pos  out  3  index of value in sequence table
- dir_up  out  1  1 = ascending table walk, 0 = descending
- locked  out  1  FSM in TRACK
- step  out  1  one-cycle pulse on each legal sequence step
- err  out  1  one-cycle pulse on each sequence or decode error

Behaviour:
- Sequence table, cyclic, index 0..7: 5,10,15,4,9,14,3,8. Index arithmetic is mod 8, so 7+1=0 and 0−1=7.
- Digit decode, active-low codes:
  - 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x10.
  - Tens blank (0x7F) decodes as 0.
  - Any other code is illegal.
- Deglitch:
  - Both buses are registered once; the registered pair is the candidate.
  - A candidate differing from the previous registered pair reloads the stability counter to 1.
  - When the counter reaches STABLE_CYC, the candidate is accepted once.
  - A pair present on the inputs for fewer than STABLE_CYC cycles is ignored.
- Latency: outputs update on the edge after acceptance, i.e. STABLE_CYC+1 edges after the input change.
- An accepted pair equal to the last accepted pair produces no event.
- Reset: state=SYNC, value=0, value_valid=0, pos=0, dir_up=1, locked=0, step=0, err=0, candidate=0x7F/0x7F, counter=0. Reset asserted mid-deglitch or mid-operation discards all history.
- FSM, evaluated on each accepted new value v:
  - SYNC:
    - v in table → pos=idx(v), go LOCK1.
    - v legal but not in table → stay, no err.
    - v illegal → value_valid=0, no err.
  - LOCK1:
    - v=sec[pos+1] → dir_up=1, step, go TRACK.
    - v=sec[pos−1] → dir_up=0, step, go TRACK.
    - v elsewhere in table → err, pos=idx(v), stay.
    - v not in table or illegal → err, go SYNC.
  - TRACK:
    - v equals the expected next entry in the current direction → pos updated, step.
    - v equals the opposite neighbour → dir_up toggles, pos updated, step, no err (legal direction change).
    - v elsewhere in table → err, pos=idx(v), go LOCK1.
    - v not in table or illegal → err, value_valid=0, go SYNC.
- step and err are never asserted in the same cycle.
- value and value_valid update on every accepted pair; value holds its previous contents when the pair is illegal.

Optional Feature:
- Macro SEQ7SEG_ERRCNT_EN.
- Defined: adds output err_cnt [7:0], reset to 0, incremented on each err pulse, saturating at 255.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package seq7seg_pkg holds:
  - SEQ_LEN=8 and the sequence table constant;
  - the ten active-low digit codes plus the blank code;
  - enum state_t {SYNC, LOCK1, TRACK}.
- Sub-module seg7_to_digit (combinational, code → {legal, digit[n-1:0]}), instantiated twice.
- The top module owns the deglitch logic, table lookup and FSM.

Test Plan:
- Reset, hold 0x40/0x12 ("05") for 6 cycles → value=5, value_valid=1, pos=0, locked=0, no step/err.
- "05"→"10"(0x79/0x40)→"15"(0x79/0x12), each held 6 cycles → step at each change, dir_up=1, locked=1, pos=1 then 2.
- "10"→"05"→"08"(0x40/0x00) → dir_up=0, pos 0 then 7, two steps, no err. Then "05" → dir_up=1, step, no err.
- Locked at "05", present "10" for 2 cycles then back to "05" → no step, no err, value stays 5.
- Locked up at "10", present "04"(0x40/0x19) → err pulse, pos=3, locked=0. Then seg0=0x7E → err, value_valid=0, state SYNC. With SEQ7SEG_ERRCNT_EN, err_cnt=2.
- Assert reset for 1 cycle while a new pair has been held for 2 cycles → all outputs at reset values next edge, no step afterwards.

Source files
------------

// File: rtl/seq7seg_pkg.sv
// Shared definitions for the 7-segment sequence monitor: sequence table,
// active-low digit codes, FSM state type and table helper functions.
package seq7seg_pkg;

   localparam int SEQ_LEN = 8;

   // Sequence table, entry i lives in bits [4*i +: 4]: 5,10,15,4,9,14,3,8
   localparam logic [4*SEQ_LEN-1:0] SEQ_TABLE = {4'd8, 4'd3, 4'd14, 4'd9,
                                                 4'd4, 4'd15, 4'd10, 4'd5};

   // Active-low segment codes, bit0=a .. bit6=g
   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LOCK1 = 2'd1,
      TRACK = 2'd2
   } state_t;

   // Table entry at a (mod 8) index
   function automatic logic [3:0] seq_at(input logic [2:0] idx);
      return SEQ_TABLE[{idx, 2'b00} +: 4];
   endfunction

   // Table search: returns {hit, index}; index is 0 when there is no hit
   function automatic logic [3:0] seq_find(input logic [6:0] v);
      logic [3:0] res;
      res = 4'b0000;
      for (int i = 0; i < SEQ_LEN; i++) begin
         if (v == {3'b000, seq_at(3'(i))}) begin
            res = {1'b1, 3'(i)};
         end else begin
            res = res;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seq7seg_monitor_seg7_to_digit.sv
// Active-low 7-segment code to BCD digit decoder. BLANK_OK lets the
// all-off pattern decode as 0 (used for a blanked tens digit).
module seg7_to_digit
   import seq7seg_pkg::*;
#(
   parameter int n        = 4,
   parameter bit BLANK_OK = 1'b0
) (
   input  logic [6:0]   code,
   output logic         legal,
   output logic [n-1:0] digit
);

   // Map each recognised code to its digit; everything else is illegal
   always_comb begin
      legal = 1'b1;
      digit = n'(4'd0);
      case (code)
         SEG_0:     digit = n'(4'd0);
         SEG_1:     digit = n'(4'd1);
         SEG_2:     digit = n'(4'd2);
         SEG_3:     digit = n'(4'd3);
         SEG_4:     digit = n'(4'd4);
         SEG_5:     digit = n'(4'd5);
         SEG_6:     digit = n'(4'd6);
         SEG_7:     digit = n'(4'd7);
         SEG_8:     digit = n'(4'd8);
         SEG_9:     digit = n'(4'd9);
         SEG_BLANK: legal = BLANK_OK;
         default:   legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/seq7seg_monitor.sv
// Receive-side checker for the two-digit sequence display: deglitches the
// seg1/seg0 buses, decodes the value, locates it in the sequence table and
// tracks the walk direction, pulsing step on legal moves and err otherwise.
// Optional build macro SEQ7SEG_ERRCNT_EN adds a saturating err_cnt output.
module seq7seg_monitor
   import seq7seg_pkg::*;
#(
   parameter int n          = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] seg1,
   input  logic [6:0] seg0,
   output logic [6:0] value,
   output logic       value_valid,
   output logic [2:0] pos,
   output logic       dir_up,
   output logic       locked,
   output logic       step,
   output logic       err
`ifdef SEQ7SEG_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYC);

   // Deglitch state: candidate pair, hold counter, one-shot accept flag
   logic [6:0] seg1_r;
   logic [6:0] seg0_r;
   logic [3:0] cnt_r;
   logic       acc_r;

   // Last accepted pair, used to suppress repeated acceptances
   logic [13:0] last_pair_r;
   logic        last_vld_r;

   // FSM and output registers
   state_t     state_r, state_s;
   logic [6:0] value_r, value_s;
   logic       value_valid_r, value_valid_s;
   logic [2:0] pos_r, pos_s;
   logic       dir_up_r, dir_up_s;
   logic       locked_r;
   logic       step_r, step_s;
   logic       err_r, err_s;

   // Decode of the candidate pair
   logic         tens_legal_s, units_legal_s, legal_s;
   logic [n-1:0] tens_s, units_s;
   logic [6:0]   v_s;
   logic [3:0]   find_s;
   logic         hit_s;
   logic [2:0]   idx_s;
   logic [2:0]   pos_inc_s, pos_dec_s, ahead_s, behind_s;
   logic         new_evt_s;

   seg7_to_digit #(.n(n), .BLANK_OK(1'b1)) u_tens (
      .code  (seg1_r),
      .legal (tens_legal_s),
      .digit (tens_s)
   );

   seg7_to_digit #(.n(n), .BLANK_OK(1'b0)) u_units (
      .code  (seg0_r),
      .legal (units_legal_s),
      .digit (units_s)
   );

   assign legal_s   = tens_legal_s & units_legal_s;
   assign v_s       = 7'(tens_s) * 7'd10 + 7'(units_s);
   assign find_s    = seq_find(v_s);
   assign hit_s     = legal_s & find_s[3];
   assign idx_s     = find_s[2:0];
   assign pos_inc_s = pos_r + 3'd1;
   assign pos_dec_s = pos_r - 3'd1;
   assign ahead_s   = dir_up_r ? pos_inc_s : pos_dec_s;
   assign behind_s  = dir_up_r ? pos_dec_s : pos_inc_s;
   assign new_evt_s = acc_r & ~(last_vld_r & (last_pair_r == {seg1_r, seg0_r}));

   // Register the buses and count how long the candidate pair has been held
   always_ff @(posedge clk) begin
      if (reset) begin
         seg1_r <= SEG_BLANK;
         seg0_r <= SEG_BLANK;
         cnt_r  <= 4'd0;
         acc_r  <= 1'b0;
      end else if ({seg1, seg0} != {seg1_r, seg0_r}) begin
         seg1_r <= seg1;
         seg0_r <= seg0;
         cnt_r  <= 4'd1;
         acc_r  <= (STABLE_LIM == 4'd1);
      end else if (cnt_r < STABLE_LIM) begin
         cnt_r  <= cnt_r + 4'd1;
         acc_r  <= ((cnt_r + 4'd1) == STABLE_LIM);
      end else begin
         acc_r  <= 1'b0;
      end
   end

   // Next-state and output decision for each newly accepted pair
   always_comb begin
      state_s       = state_r;
      pos_s         = pos_r;
      dir_up_s      = dir_up_r;
      value_s       = value_r;
      value_valid_s = value_valid_r;
      step_s        = 1'b0;
      err_s         = 1'b0;
      if (new_evt_s) begin
         value_valid_s = legal_s;
         if (legal_s) begin
            value_s = v_s;
         end else begin
            value_s = value_r;
         end
         case (state_r)
            SYNC: begin
               if (hit_s) begin
                  pos_s   = idx_s;
                  state_s = LOCK1;
               end else begin
                  state_s = SYNC;
               end
            end
            LOCK1: begin
               if (!hit_s) begin
                  err_s   = 1'b1;
                  state_s = SYNC;
               end else if (idx_s == pos_inc_s) begin
                  dir_up_s = 1'b1;
                  pos_s    = idx_s;
                  step_s   = 1'b1;
                  state_s  = TRACK;
               end else if (idx_s == pos_dec_s) begin
                  dir_up_s = 1'b0;
                  pos_s    = idx_s;
                  step_s   = 1'b1;
                  state_s  = TRACK;
               end else begin
                  err_s    = 1'b1;
                  pos_s    = idx_s;
               end
            end
            TRACK: begin
               if (!hit_s) begin
                  err_s   = 1'b1;
                  state_s = SYNC;
               end else if (idx_s == ahead_s) begin
                  pos_s   = idx_s;
                  step_s  = 1'b1;
               end else if (idx_s == behind_s) begin
                  dir_up_s = ~dir_up_r;
                  pos_s    = idx_s;
                  step_s   = 1'b1;
               end else begin
                  err_s   = 1'b1;
                  pos_s   = idx_s;
                  state_s = LOCK1;
               end
            end
            default: begin
               state_s = SYNC;
            end
         endcase
      end else begin
         state_s = state_r;
      end
   end

   // State, output and last-accepted-pair registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= SYNC;
         value_r       <= 7'd0;
         value_valid_r <= 1'b0;
         pos_r         <= 3'd0;
         dir_up_r      <= 1'b1;
         locked_r      <= 1'b0;
         step_r        <= 1'b0;
         err_r         <= 1'b0;
         last_pair_r   <= 14'd0;
         last_vld_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         value_r       <= value_s;
         value_valid_r <= value_valid_s;
         pos_r         <= pos_s;
         dir_up_r      <= dir_up_s;
         locked_r      <= (state_s == TRACK);
         step_r        <= step_s;
         err_r         <= err_s;
         if (acc_r) begin
            last_pair_r <= {seg1_r, seg0_r};
            last_vld_r  <= 1'b1;
         end else begin
            last_pair_r <= last_pair_r;
            last_vld_r  <= last_vld_r;
         end
      end
   end

`ifdef SEQ7SEG_ERRCNT_EN
   logic [7:0] err_cnt_r;

   // Count error pulses, saturating at 255
   always_ff @(posedge clk) begin
      if (reset) begin
         err_cnt_r <= 8'd0;
      end else if (err_s && (err_cnt_r != 8'hFF)) begin
         err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
         err_cnt_r <= err_cnt_r;
      end
   end

   assign err_cnt = err_cnt_r;
`endif

   assign value       = value_r;
   assign value_valid = value_valid_r;
   assign pos         = pos_r;
   assign dir_up      = dir_up_r;
   assign locked      = locked_r;
   assign step        = step_r;
   assign err         = err_r;

endmodule
